// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Captures the control word produced by the control-zeroing stall mux plus the
// ID-stage operands and register specifiers once per cycle. A valid bit
// travels with the instruction so that bubbles stay identifiable downstream.
//
// Per rising edge, priority flush > hold > load:
//   flush : control outputs and valid_out cleared; data/specifiers still load
//   hold  : every stored field (and the bubble counter) keeps its value
//   load  : every field takes its *_in value (1-cycle latency)
// All outputs are flop Q; there is no combinational input->output path.
//
// Ports:
//   clk, reset_n (async, active-low), hold, flush, valid_in
//   RegDst/ALUSrc/MemToReg/RegWrite/MemRead/MemWrite/Branch _in/_out (1 bit)
//   ALUOp_in/_out (2 bits)
//   pc_plus4, rd_data1, rd_data2, imm _in/_out (DATA_W)
//   rs, rt, rd _in/_out (REG_ADDR_W)
//   valid_out
//   bubble_cnt (CNT_W) -- only when ID_EX_PERF_CNT_EN is defined
//
// Optional feature macro: ID_EX_PERF_CNT_EN
//   Adds a saturating counter of edges that load a bubble (flush, or a
//   non-held load with valid_in=0).
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  RegDst_in,
  input  logic                  ALUSrc_in,
  input  logic                  MemToReg_in,
  input  logic                  RegWrite_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  Branch_in,
  input  logic [1:0]            ALUOp_in,
  input  logic [DATA_W-1:0]     pc_plus4_in,
  input  logic [DATA_W-1:0]     rd_data1_in,
  input  logic [DATA_W-1:0]     rd_data2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  valid_out,
  output logic                  RegDst_out,
  output logic                  ALUSrc_out,
  output logic                  MemToReg_out,
  output logic                  RegWrite_out,
  output logic                  MemRead_out,
  output logic                  MemWrite_out,
  output logic                  Branch_out,
  output logic [1:0]            ALUOp_out,
  output logic [DATA_W-1:0]     pc_plus4_out,
  output logic [DATA_W-1:0]     rd_data1_out,
  output logic [DATA_W-1:0]     rd_data2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out    <= 1'b0;
      RegDst_out   <= 1'b0;
      ALUSrc_out   <= 1'b0;
      MemToReg_out <= 1'b0;
      RegWrite_out <= 1'b0;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      Branch_out   <= 1'b0;
      ALUOp_out    <= 2'b00;
      pc_plus4_out <= '0;
      rd_data1_out <= '0;
      rd_data2_out <= '0;
      imm_out      <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
    end else if (flush || !hold) begin
      // A flush overrides hold so a taken branch can never be frozen in EX;
      // only the control word and valid bit are forced to the bubble value.
      valid_out    <= flush ? 1'b0 : valid_in;
      RegDst_out   <= flush ? 1'b0 : RegDst_in;
      ALUSrc_out   <= flush ? 1'b0 : ALUSrc_in;
      MemToReg_out <= flush ? 1'b0 : MemToReg_in;
      RegWrite_out <= flush ? 1'b0 : RegWrite_in;
      MemRead_out  <= flush ? 1'b0 : MemRead_in;
      MemWrite_out <= flush ? 1'b0 : MemWrite_in;
      Branch_out   <= flush ? 1'b0 : Branch_in;
      ALUOp_out    <= flush ? 2'b00 : ALUOp_in;
      pc_plus4_out <= pc_plus4_in;
      rd_data1_out <= rd_data1_in;
      rd_data2_out <= rd_data2_in;
      imm_out      <= imm_in;
      rs_out       <= rs_in;
      rt_out       <= rt_in;
      rd_out       <= rd_in;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic bubbleLoad;
  assign bubbleLoad = flush || (!hold && !valid_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
    end else if (bubbleLoad) begin
      bubble_cnt <= satInc(bubble_cnt);
    end
  end
`endif

endmodule
